// File: rtl/dm_pkg.sv
// ---------------------------------------------------------------------------
// dm_pkg
// Shared definitions for the data-memory bus responder:
//   - access size encodings carried on req_size
//   - responder FSM state encoding
//   - width of the wait-state counter
// ---------------------------------------------------------------------------
package dm_pkg;

    // Access size encodings
    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    // Wait-state counter width (supports 0..15 wait states)
    localparam int CNT_W = 4;

    // Responder FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dm_state_e;

endpackage

// File: rtl/dm_lane_align.sv
// ---------------------------------------------------------------------------
// dm_lane_align
// Combinational byte-lane helper for the data-memory responder.
//   Store path: merges the selected lane(s) of right-justified write data
//               into the old memory word.
//   Load path : extracts the addressed lane(s) and zero/sign-extends them.
// Ports:
//   i_old_word  [31:0]  current contents of the addressed word
//   i_wdata     [31:0]  right-justified store data
//   i_size      [1:0]   access size (SZ_WORD/SZ_HALF/SZ_BYTE)
//   i_lane      [1:0]   byte address bits [1:0]
//   i_sign              sign-extend loads (half/byte only)
//   o_new_word  [31:0]  merged word for a store
//   o_load_data [31:0]  extended load result
// ---------------------------------------------------------------------------
module dm_lane_align
    import dm_pkg::*;
(
    input  logic [31:0] i_old_word,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_lane,
    input  logic        i_sign,
    output logic [31:0] o_new_word,
    output logic [31:0] o_load_data
);

    logic [3:0]  w_be;     // byte enables for the merge
    logic [31:0] w_rep;    // store data replicated across all lanes
    logic [31:0] w_shift;  // old word shifted so the addressed lane is at bit 0

    always_comb begin
        w_be  = 4'b0000;
        w_rep = i_wdata;
        case (i_size)
            SZ_WORD: begin
                w_be  = 4'b1111;
                w_rep = i_wdata;
            end
            SZ_HALF: begin
                w_be  = i_lane[1] ? 4'b1100 : 4'b0011;
                w_rep = {2{i_wdata[15:0]}};
            end
            SZ_BYTE: begin
                w_be  = 4'b0001 << i_lane;
                w_rep = {4{i_wdata[7:0]}};
            end
            default: begin
                w_be  = 4'b0000;
                w_rep = i_wdata;
            end
        endcase
    end

    // Per-lane merge: enabled lanes take replicated data, others keep old bytes
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign o_new_word[8*gi +: 8] = w_be[gi] ? w_rep[8*gi +: 8]
                                                    : i_old_word[8*gi +: 8];
        end
    endgenerate

    // Word loads are always lane 0 when legal; misaligned ones are zeroed upstream
    assign w_shift = i_old_word >> {i_lane, 3'b000};

    always_comb begin
        o_load_data = 32'h0000_0000;
        case (i_size)
            SZ_WORD: o_load_data = w_shift;
            SZ_HALF: o_load_data = {(i_sign ? {16{w_shift[15]}} : 16'h0000), w_shift[15:0]};
            SZ_BYTE: o_load_data = {(i_sign ? {24{w_shift[7]}}  : 24'h00_0000), w_shift[7:0]};
            default: o_load_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/dm_bus_responder.sv
// ---------------------------------------------------------------------------
// dm_bus_responder
// Multi-cycle data-memory responder for the pipelined MIPS core. Accepts one
// load/store at a time over valid/ready, waits WAIT_CYCLES, then pulses
// resp_valid with registered read data / error flag. Stores are committed at
// the clock edge that ends the response cycle.
// Parameters: DEPTH (words, power of two), BASE (byte address of word 0),
//             WAIT_CYCLES (0..15).
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   req_valid/req_ready   request handshake (accepted only in IDLE)
//   req_we, req_size,     store enable, access size, sign-extend,
//   req_sign, req_addr,   byte address, right-justified store data,
//   req_wdata, req_pc     PC of the issuing instruction (trace only)
//   resp_valid            one-cycle response strobe
//   resp_rdata, resp_err  registered result/error, held until next response
//   busy                  core stall (includes the accept cycle)
// Optional build macro DM_TRACE_EN: prints every committed store as
//   "@<pc>: *<word address> <= <merged word>".
// ---------------------------------------------------------------------------
module dm_bus_responder
    import dm_pkg::*;
#(
    parameter int          DEPTH       = 4096,
    parameter logic [31:0] BASE        = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_sign,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int              IDX_W    = $clog2(DEPTH);
    // One past the last legal byte address, in 33 bits so it cannot wrap
    localparam logic [32:0]     LIMIT    = {1'b0, BASE} + (33'(DEPTH) * 33'd4);
    localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1)
                                                             : '0;

    // State and latched request fields
    dm_state_e        r_state;
    dm_state_e        w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_we;
    logic [1:0]       r_size;
    logic             r_sign;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [31:0]      r_resp_rdata;
    logic             r_resp_err;

    logic [31:0]      r_mem [DEPTH];

    // Request source: live inputs in IDLE (needed when WAIT_CYCLES=0 jumps
    // straight to RESP on the accept edge), latched fields otherwise.
    logic             w_idle;
    logic             w_src_we;
    logic [1:0]       w_src_size;
    logic             w_src_sign;
    logic [31:0]      w_src_addr;
    logic [31:0]      w_src_wdata;

    logic             w_align_err;
    logic             w_range_err;
    logic             w_size_err;
    logic             w_err;
    logic [IDX_W-1:0] w_idx;
    logic [31:0]      w_old_word;
    logic [31:0]      w_new_word;
    logic [31:0]      w_load_data;
    logic             w_accept;
    logic             w_resp_load;
    logic             w_commit;

    assign w_idle      = (r_state == ST_IDLE);
    assign w_accept    = w_idle && req_valid;

    assign w_src_we    = w_idle ? req_we    : r_we;
    assign w_src_size  = w_idle ? req_size  : r_size;
    assign w_src_sign  = w_idle ? req_sign  : r_sign;
    assign w_src_addr  = w_idle ? req_addr  : r_addr;
    assign w_src_wdata = w_idle ? req_wdata : r_wdata;

    // Error detection
    assign w_align_err = ((w_src_size == SZ_WORD) && (w_src_addr[1:0] != 2'b00)) ||
                         ((w_src_size == SZ_HALF) && w_src_addr[0]);
    assign w_range_err = ({1'b0, w_src_addr} < {1'b0, BASE}) ||
                         ({1'b0, w_src_addr} >= LIMIT);
    assign w_size_err  = (w_src_size == SZ_RSVD);
    assign w_err       = w_align_err || w_range_err || w_size_err;

    // Word index; only meaningful when the address is in range
    assign w_idx       = IDX_W'((w_src_addr - BASE) >> 2);
    assign w_old_word  = r_mem[w_idx];

    dm_lane_align u_lane_align (
        .i_old_word  (w_old_word),
        .i_wdata     (w_src_wdata),
        .i_size      (w_src_size),
        .i_lane      (w_src_addr[1:0]),
        .i_sign      (w_src_sign),
        .o_new_word  (w_new_word),
        .o_load_data (w_load_data)
    );

    // Next-state and counter logic
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (WAIT_CYCLES > 0) begin
                        w_state_next = ST_WAIT;
                        w_cnt_next   = CNT_LOAD;
                    end else begin
                        w_state_next = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_next = ST_RESP;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            ST_RESP: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Response registers load on the edge that enters RESP
    assign w_resp_load = (w_state_next == ST_RESP) && (r_state != ST_RESP);
    // Stores commit on the edge that leaves RESP
    assign w_commit    = (r_state == ST_RESP) && r_we && !w_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_we    <= 1'b0;
            r_size  <= SZ_WORD;
            r_sign  <= 1'b0;
            r_addr  <= 32'h0000_0000;
            r_wdata <= 32'h0000_0000;
        end else if (w_accept) begin
            r_we    <= req_we;
            r_size  <= req_size;
            r_sign  <= req_sign;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_resp_rdata <= 32'h0000_0000;
            r_resp_err   <= 1'b0;
        end else if (w_resp_load) begin
            r_resp_err   <= w_err;
            r_resp_rdata <= (w_err || w_src_we) ? 32'h0000_0000 : w_load_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 32'h0000_0000;
            end
        end else if (w_commit) begin
            r_mem[w_idx] <= w_new_word;
        end
    end

`ifdef DM_TRACE_EN
    logic [31:0] r_pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc <= 32'h0000_0000;
        end else if (w_accept) begin
            r_pc <= req_pc;
        end
    end

    always @(posedge clk) begin
        if (!reset && w_commit) begin
            $display("@%h: *%h <= %h", r_pc, {w_src_addr[31:2], 2'b00}, w_new_word);
        end
    end
`else
    // PC is only consumed by the store trace
    logic w_unused_pc;
    assign w_unused_pc = ^req_pc;
`endif

    assign req_ready  = w_idle;
    assign resp_valid = (r_state == ST_RESP);
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;
    assign busy       = !w_idle || req_valid;

endmodule
